uart_mem_loader: RTL and testbench

Serial program/data loader that writes into data RAM through the RAM's CPU-side write port. The loader receives a framed byte stream on a UART pin, assembles DATA_WIDTH words, writes them to consecutive RAM addresses from 0, and holds the CPU in reset while loading. The RAM and the VGA screen path read the words back unchanged.

---
 rtl/loader_pkg.sv | 28 ++
 rtl/uart_rx.sv | 97 +++++++++
 rtl/uart_mem_loader.sv | 137 +++++++++++++
 tb/tb_uart_mem_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART memory loader.
// LOADER_CHECKSUM_EN adds the CHECK state to the loader FSM.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         CHK_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Emits a one-cycle rx_valid with the byte, or rx_ferr when the stop bit is low.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLK_50,
  input  logic       resetN,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    r_sync;
  logic          r_prev;
  rx_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_valid, w_valid;
  logic          r_ferr, w_ferr;
  logic          w_line;

  assign w_line   = r_sync[1];
  assign rx_byte  = r_shift;
  assign rx_valid = r_valid;
  assign rx_ferr  = r_ferr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = CW'(r_cnt + 1'b1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid     = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      R_IDLE: begin
        w_cnt_nxt = '0;
        if (r_prev && !w_line) w_state_nxt = R_START;
      end
      R_START: begin
        // A line that is high again at half a bit was only a glitch.
        if (r_cnt == HALF) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_line ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (r_cnt == FULL) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_line, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = R_STOP;
        end
      end
      R_STOP: begin
        if (r_cnt == FULL) begin
          w_cnt_nxt   = '0;
          w_state_nxt = R_IDLE;
          w_valid     = w_line;
          w_ferr      = !w_line;
        end
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], uart_rx};
      r_prev  <= w_line;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Loads a framed UART byte stream into RAM as 16-bit words from address 0, holding the CPU meanwhile.
// Define LOADER_CHECKSUM_EN to expect and verify a trailing 8-bit sum byte.
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  CLK_50,
  input  logic                  resetN,
  input  logic                  uart_rx,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHECK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  logic [7:0]          w_rx_byte;
  logic                w_rx_valid, w_rx_ferr;
  state_t              r_state, w_state_nxt;
  logic [ADDR_WIDTH:0] r_addr, r_len;
  logic [7:0]          r_len_hi, r_hi;
  logic [15:0]         w_len;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                r_we, r_hold, r_done, r_err;
  logic                w_issue, w_sync, w_last, w_busy;
`ifdef LOADER_CHECKSUM_EN
  logic [CHK_W-1:0]    r_sum;
`endif

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK_50   (CLK_50),
    .resetN   (resetN),
    .uart_rx  (uart_rx),
    .rx_byte  (w_rx_byte),
    .rx_valid (w_rx_valid),
    .rx_ferr  (w_rx_ferr)
  );

  assign w_len  = {r_len_hi, w_rx_byte};
  assign w_last = r_we && ((r_addr + 1'b1) == r_len);
  assign w_busy = !(r_state inside {S_IDLE, S_DONE, S_ERROR});

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_sync      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_rx_valid && w_rx_byte == SYNC_BYTE) begin
          w_state_nxt = S_LEN_HI;
          w_sync      = 1'b1;
        end
      end
      S_LEN_HI: if (w_rx_valid) w_state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (w_rx_valid) begin
          if (w_len == 16'd0)                         w_state_nxt = S_FINISH;
          else if (int'(w_len) > (1 << ADDR_WIDTH))   w_state_nxt = S_ERROR;
          else                                        w_state_nxt = S_DATA_HI;
        end
      end
      // The final write is judged the cycle after it issues, so hold drops after mem_we.
      S_DATA_HI: begin
        if (w_last)          w_state_nxt = S_FINISH;
        else if (w_rx_valid) w_state_nxt = S_DATA_LO;
      end
      S_DATA_LO: begin
        if (w_rx_valid) begin
          w_state_nxt = S_DATA_HI;
          w_issue     = 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (w_rx_valid) w_state_nxt = (w_rx_byte == r_sum) ? S_DONE : S_ERROR;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_rx_ferr && w_busy) w_state_nxt = S_ERROR;
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_len_hi <= '0;
      r_hi     <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_hold   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_issue;
      r_hold  <= !(w_state_nxt inside {S_IDLE, S_DONE, S_ERROR});
      r_done  <= (w_state_nxt == S_DONE);
      r_err   <= (w_state_nxt == S_ERROR);
      if (w_issue)                              r_wdata  <= DATA_WIDTH'({r_hi, w_rx_byte});
      if (r_state == S_LEN_HI && w_rx_valid)    r_len_hi <= w_rx_byte;
      if (r_state == S_LEN_LO && w_rx_valid)    r_len    <= w_len[ADDR_WIDTH:0];
      if (r_state == S_DATA_HI && w_rx_valid)   r_hi     <= w_rx_byte;
      if (w_sync)    r_addr <= '0;
      else if (r_we) r_addr <= r_addr + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      r_sum <= '0;
    end else if (w_sync) begin
      r_sum <= '0;
    end else if (w_rx_valid && r_state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO}) begin
      r_sum <= r_sum + w_rx_byte;
    end
  end
`endif

  assign mem_addr   = r_addr[ADDR_WIDTH-1:0];
  assign mem_wdata  = r_wdata;
  assign mem_we     = r_we;
  assign cpu_hold   = r_hold;
  assign load_done  = r_done;
  assign load_error = r_err;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader; follows LOADER_CHECKSUM_EN to send or omit the CHK byte.
module tb_uart_mem_loader;

  localparam int CPB = 16;
  localparam int AW  = 12;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          resetN;
  logic          rx_line;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, cpu_hold, load_done, load_error;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] wr_addr [0:31];
  logic [DW-1:0] wr_data [0:31];
  logic          wr_hold [0:31];
  int            wr_n = 0;
  int            base;

  always #5 clk = ~clk;

  uart_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLKS_PER_BIT(CPB)) dut (
    .CLK_50     (clk),
    .resetN     (resetN),
    .uart_rx    (rx_line),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1 && wr_n < 32) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_hold[wr_n] = cpu_hold;
      wr_n = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    rx_line = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx_line = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(posedge clk);
    rx_line = 1'b1;
    repeat (bad_stop ? CPB + 4 : 4) @(posedge clk);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, "_we"}, 32'(mem_we), 32'h0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'h0);
    check({tag, "_done"}, 32'(load_done), 32'h0);
    check({tag, "_err"}, 32'(load_error), 32'h0);
  endtask

  initial begin
    rx_line = 1'b1;
    resetN  = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    resetN = 1'b1;
    repeat (5) @(posedge clk);

    // Two-word load
    base = wr_n;
    send_byte(8'hA5);
    @(negedge clk);
    check("t1_hold_after_sync", 32'(cpu_hold), 32'h1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
`ifdef LOADER_CHECKSUM_EN
    @(negedge clk);
    check("t1_hold_before_chk", 32'(cpu_hold), 32'h1);
    send_byte(8'hC0);
`endif
    settle();
    check("t1_nwrites", wr_n - base, 2);
    check("t1_addr0", 32'(wr_addr[base]), 32'h0);
    check("t1_data0", 32'(wr_data[base]), 32'h1234);
    check("t1_addr1", 32'(wr_addr[base+1]), 32'h1);
    check("t1_data1", 32'(wr_data[base+1]), 32'hABCD);
    check("t1_hold_at_we", 32'({wr_hold[base], wr_hold[base+1]}), 32'h3);
    check("t1_addr_after", 32'(mem_addr), 32'h2);
    check("t1_done", 32'(load_done), 32'h1);
    check("t1_err", 32'(load_error), 32'h0);
    check("t1_hold_end", 32'(cpu_hold), 32'h0);

`ifdef LOADER_CHECKSUM_EN
    // Same frame with a wrong checksum
    base = wr_n;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h00);
    settle();
    check("t2_nwrites", wr_n - base, 2);
    check("t2_data1", 32'(wr_data[base+1]), 32'hABCD);
    check("t2_done", 32'(load_done), 32'h0);
    check("t2_err", 32'(load_error), 32'h1);
`endif

    // Zero-length load
    base = wr_n;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    settle();
    check("t3_nwrites", wr_n - base, 0);
    check("t3_done", 32'(load_done), 32'h1);
    check("t3_err", 32'(load_error), 32'h0);
    check("t3_addr", 32'(mem_addr), 32'h0);

    // Length one past capacity
    base = wr_n;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01);
    settle();
    check("t4_nwrites", wr_n - base, 0);
    check("t4_err", 32'(load_error), 32'h1);
    check("t4_done", 32'(load_done), 32'h0);
    check("t4_hold", 32'(cpu_hold), 32'h0);

    // Framing error on the third data byte
    base = wr_n;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB, 1'b1);
    settle();
    check("t5_nwrites", wr_n - base, 1);
    check("t5_addr0", 32'(wr_addr[base]), 32'h0);
    check("t5_data0", 32'(wr_data[base]), 32'h1234);
    check("t5_err", 32'(load_error), 32'h1);
    check("t5_hold", 32'(cpu_hold), 32'h0);

    // Reset in the middle of a word, then a clean reload
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h56);
    @(negedge clk);
    check("t6_hold_before_rst", 32'(cpu_hold), 32'h1);
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("t6_rst");
    resetN = 1'b1;
    repeat (5) @(posedge clk);
    base = wr_n;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hBE); send_byte(8'hEF);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hAE);
`endif
    settle();
    check("t6_nwrites", wr_n - base, 1);
    check("t6_addr0", 32'(wr_addr[base]), 32'h0);
    check("t6_data0", 32'(wr_data[base]), 32'hBEEF);
    check("t6_done", 32'(load_done), 32'h1);
    check("t6_err", 32'(load_error), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
